// File: rtl/tmcu_pkg.sv
// Shared definitions for the TX scheduler: register offsets, CTRL/STATUS bit
// positions and the scheduler state encoding.
package tmcu_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_BUSY_BIT   = 2;
    localparam int STAT_CNT_LSB    = 4;
    localparam int STAT_CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/tmcu_sync_fifo.sv
// Circular single-clock FIFO with a combinational head word; pushes into a full
// FIFO and pops from an empty one are ignored.
module tmcu_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/uart_tx_sched.sv
// APB-programmed TX byte scheduler: buffers bytes in a FIFO and hands them one
// at a time to a UART transmitter using a start/ready handshake.
module uart_tx_sched
    import tmcu_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);

    tx_state_t   state_reg, state_next;
    logic [1:0]  wait_cnt_reg, wait_cnt_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        en_reg, ie_reg, irq_reg;
    logic        access, sel_data, sel_status, sel_ctrl, sel_bad;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic [CW-1:0] fifo_count;
    logic [31:0] status_word;
    logic        unused_bits;

    assign access     = psel & penable;
    assign sel_data   = (paddr[3:2] == OFF_DATA[3:2]);
    assign sel_status = (paddr[3:2] == OFF_STATUS[3:2]);
    assign sel_ctrl   = (paddr[3:2] == OFF_CTRL[3:2]);
    assign sel_bad    = ~(sel_data | sel_status | sel_ctrl);
    assign fifo_push  = access & pwrite & sel_data;
    assign unused_bits = ^{pwdata[31:8], paddr[1:0]};

    tmcu_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (pwdata[7:0]),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_reg <= 1'b0;
            ie_reg <= 1'b0;
        end else if (access && pwrite && sel_ctrl) begin
            en_reg <= pwdata[CTRL_EN_BIT];
            ie_reg <= pwdata[CTRL_IE_BIT];
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_BUSY_BIT]  = (state_reg != ST_IDLE);
        status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    end

    always_comb begin
        prdata = '0;
        if (rst_n && access) begin
            if (sel_status) prdata = status_word;
            else if (sel_ctrl) begin
                prdata[CTRL_EN_BIT] = en_reg;
                prdata[CTRL_IE_BIT] = ie_reg;
            end
        end
    end

    assign pready  = 1'b1;
    assign pslverr = rst_n & access &
                     (sel_bad | (pwrite & sel_status) | (pwrite & sel_data & fifo_full));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 2'd0;
            tx_data_reg  <= 8'd0;
            irq_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            tx_data_reg  <= tx_data_next;
            irq_reg      <= ie_reg & fifo_empty & (state_reg == ST_IDLE);
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        tx_data_next  = tx_data_reg;
        fifo_pop      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (en_reg && !fifo_empty && tx_ready) begin
                    state_next   = ST_START;
                    tx_data_next = fifo_head;
                    fifo_pop     = 1'b1;
                end
            end
            ST_START: begin
                state_next    = ST_WAIT_BUSY;
                wait_cnt_next = 2'd0;
            end
            ST_WAIT_BUSY: begin
                // A UART that never drops ready took the byte instantly; give up after 4 cycles.
                if (!tx_ready)                state_next = ST_WAIT_DONE;
                else if (wait_cnt_reg == 2'd3) state_next = ST_IDLE;
                else                          wait_cnt_next = wait_cnt_reg + 2'd1;
            end
            ST_WAIT_DONE: begin
                if (tx_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx_start = (state_reg == ST_START);
    assign tx_data  = tx_data_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: expected bytes queue up as DATA is written and
// a monitor checks each tx_start against the queue head.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, tx_start, tx_ready, irq;
    logic [7:0]  tx_data;

    int          tests = 0;
    int          fails = 0;
    int          start_cnt = 0;
    int          uart_hold = 20;
    int          base;
    logic        prev_start = 1'b0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    uart_tx_sched #(.DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor: every start must carry the oldest outstanding byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tx_start === 1'b1) begin
            start_cnt++;
            check("tx_start_one_cycle", {31'd0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_tx_start: got data 0x%0h, expected no start", tx_data);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_start = (rst_n === 1'b1) && (tx_start === 1'b1);
    end

    // UART model: drop ready one cycle after tx_start, raise it uart_hold cycles later.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_start === 1'b1 && uart_hold > 0) begin
                @(posedge clk); #1 tx_ready = 1'b0;
                repeat (uart_hold) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic exp_err, input string name);
        logic [31:0] rd_v;
        logic        err;
        apb(1'b1, a, d, rd_v, err);
        $display("[TB] apb write addr=0x%0h data=0x%0h pslverr=%0b", a, d, err);
        check({name, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp_d, input logic exp_err, input string name);
        logic [31:0] rd_v;
        logic        err;
        apb(1'b0, a, 32'd0, rd_v, err);
        check({name, "_prdata"}, rd_v, exp_d);
        check({name, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        wr(4'h0, {24'd0, b}, 1'b0, "data_push");
    endtask

    task automatic wait_starts(input int target, input string name);
        for (int i = 0; i < 3000 && start_cnt < target; i++) @(negedge clk);
        check(name, start_cnt, target);
    endtask

    task automatic wait_ready(input logic level);
        int i;
        for (i = 0; i < 200 && tx_ready !== level; i++) @(negedge clk);
        if (tx_ready !== level) begin
            tests++;
            fails++;
            $display("FAIL tx_ready_wait: got %0b, expected %0b within 200 cycles", tx_ready, level);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx_start", {31'd0, tx_start}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_pslverr", {31'd0, pslverr}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        rd(4'h4, 32'h002, 1'b0, "reset_status");
        rd(4'h8, 32'h000, 1'b0, "reset_ctrl");

        // Single byte with a slow UART
        wr(4'h8, 32'h1, 1'b0, "ctrl_en");
        base = start_cnt;
        push_byte(8'h41);
        wait_starts(base + 1, "single_start");
        rd(4'h4, 32'h006, 1'b0, "status_busy");
        wait_ready(1'b0);
        wait_ready(1'b1);
        repeat (4) @(negedge clk);
        check("single_start_count", start_cnt, base + 1);
        rd(4'h4, 32'h002, 1'b0, "status_done");

        // Fill to full with EN=0, overflow write, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) push_byte(i[7:0]);
        rd(4'h4, 32'h081, 1'b0, "status_full");
        wr(4'h0, 32'h08, 1'b1, "data_overflow");
        rd(4'h4, 32'h081, 1'b0, "status_after_overflow");
        base = start_cnt;
        wr(4'h8, 32'h1, 1'b0, "ctrl_en_drain");
        wait_starts(base + 8, "drain_starts");
        wait_ready(1'b0);
        wait_ready(1'b1);
        repeat (4) @(negedge clk);
        rd(4'h4, 32'h002, 1'b0, "status_drained");
        check("drain_queue_empty", exp_q.size(), 0);

        // Clear EN during the 3rd of 5 bytes
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + i[7:0]);
        base = start_cnt;
        wr(4'h8, 32'h1, 1'b0, "ctrl_en_five");
        wait_starts(base + 3, "third_start");
        wr(4'h8, 32'h0, 1'b0, "ctrl_clear_en");
        wait_ready(1'b0);
        wait_ready(1'b1);
        repeat (10) @(negedge clk);
        check("no_fourth_start", start_cnt, base + 3);
        rd(4'h4, 32'h020, 1'b0, "status_two_left");
        check("two_bytes_pending", exp_q.size(), 2);

        // Interrupt behaviour across two bytes
        do_reset();
        wr(4'h8, 32'h3, 1'b0, "ctrl_en_ie");
        repeat (2) @(negedge clk);
        check("irq_idle_empty", {31'd0, irq}, 32'd1);
        base = start_cnt;
        push_byte(8'h55);
        push_byte(8'h66);
        wait_starts(base + 1, "irq_first_start");
        check("irq_low_byte1", {31'd0, irq}, 32'd0);
        wait_starts(base + 2, "irq_second_start");
        check("irq_low_byte2", {31'd0, irq}, 32'd0);
        wait_ready(1'b0);
        wait_ready(1'b1);
        check("irq_low_ready_rise", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_low_first_idle", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_high_after_idle", {31'd0, irq}, 32'd1);

        // Error responses leave state untouched
        rd(4'hC, 32'h0, 1'b1, "read_bad_offset");
        wr(4'h4, 32'hFFFF_FFFF, 1'b1, "write_status");
        wr(4'hC, 32'h0, 1'b1, "write_bad_offset");
        rd(4'h0, 32'h0, 1'b0, "read_data_reg");
        rd(4'h4, 32'h002, 1'b0, "status_unchanged");
        rd(4'h8, 32'h003, 1'b0, "ctrl_unchanged");

        // UART that never drops ready: scheduler returns to idle on its own
        uart_hold = 0;
        base = start_cnt;
        push_byte(8'h5A);
        wait_starts(base + 1, "instant_start");
        repeat (8) @(negedge clk);
        rd(4'h4, 32'h002, 1'b0, "status_instant_idle");
        uart_hold = 20;

        // Reset while waiting for the UART with 3 bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(8'h10 + i[7:0]);
        base = start_cnt;
        wr(4'h8, 32'h1, 1'b0, "ctrl_en_reset_test");
        wait_starts(base + 1, "reset_test_start");
        wait_ready(1'b0);
        repeat (2) @(negedge clk);
        rd(4'h4, 32'h034, 1'b0, "status_wait_done");
        @(posedge clk); #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midtx_reset_tx_start", {31'd0, tx_start}, 32'd0);
        check("midtx_reset_tx_data", {24'd0, tx_data}, 32'd0);
        check("midtx_reset_irq", {31'd0, irq}, 32'd0);
        rd(4'h4, 32'h002, 1'b0, "midtx_reset_status");
        rd(4'h8, 32'h000, 1'b0, "midtx_reset_ctrl");
        wait_ready(1'b1);
        repeat (10) @(negedge clk);
        check("midtx_reset_no_start", start_cnt, base + 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 psel, penable, pwrite  input  1 each  APB control from the AHB-to-APB bridge.
REQ-005 paddr  input  4  register offset (word-aligned; bits [1:0] ignored).
REQ-006 pwdata  input  32  APB write data; prdata  output  32  APB read data.
REQ-007 pready  output  1  always 1 (zero wait states); pslverr  output  1  error response.
REQ-008 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  byte to transmit, stable from tx_start until tx_ready returns high.
REQ-010 tx_ready  input  1  UART idle/ready (high = can accept a byte).
REQ-011 irq  output  1  level interrupt, TX FIFO empty and scheduler idle.

Function
REQ-012 Register map: 0x0 DATA (W: push pwdata[7:0]; R: 0), 0x4 STATUS (R/O), 0x8 CTRL (R/W), other offsets read 0 with pslverr=1.
REQ-013 STATUS: bit0 full, bit1 empty, bit2 busy (state != IDLE), bits[8:4] FIFO count; other bits 0.
REQ-014 CTRL: bit0 EN (reset 0), bit1 IE (reset 0); other bits read 0.
REQ-015 Access phase = psel & penable; writes take effect at that clock edge; prdata valid combinationally in the access phase, 0 otherwise.
REQ-016 DATA write with FIFO full (count==DEPTH before the edge) is dropped and pslverr=1, even if a pop occurs the same cycle.
REQ-017 Write to STATUS: ignored, pslverr=1.
REQ-018 FIFO: circular, log2(DEPTH) pointers wrap modulo DEPTH, count width log2(DEPTH)+1; simultaneous push and pop leaves count unchanged.
REQ-019 FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> START when EN=1, FIFO not empty and tx_ready=1; head byte is latched into tx_data and popped on that edge.
REQ-021 START: tx_start=1 for exactly one cycle; -> WAIT_BUSY unconditionally.
REQ-022 WAIT_BUSY -> WAIT_DONE when tx_ready=0; -> IDLE if tx_ready stays 1 for 4 cycles (byte accepted instantly).
REQ-023 WAIT_DONE -> IDLE when tx_ready=1.
REQ-024 Back-to-back bytes: minimum one IDLE cycle between tx_ready rising and the next tx_start.
REQ-025 EN cleared mid-byte: current byte completes normally; no further starts; FIFO contents retained.
REQ-026 irq = IE & empty & (state==IDLE), registered (one cycle after condition).
REQ-027 tx_data holds last value when idle.

Reset
REQ-028 On rst_n=0 at a clock edge: state IDLE, FIFO empty (pointers and count 0), EN=0, IE=0, tx_start=0, tx_data=0, irq=0; pslverr=0, prdata=0.
REQ-029 Reset mid-transmission aborts scheduling immediately; UART-side byte in flight is not tracked after reset.

Structure
REQ-030 Shared package tmcu_pkg holds register offsets (DATA/STATUS/CTRL), CTRL/STATUS bit indices and the FSM state enum.
REQ-031 FIFO is one sub-module, tmcu_sync_fifo (parameterised DEPTH and WIDTH=8), reusable by the RX path.

Verification
REQ-032 EN=1, write 0x41 to DATA, UART model drops tx_ready 1 cycle after tx_start and raises it 20 cycles later -> single tx_start, tx_data=0x41, busy=1 for duration, then empty=1, busy=0.
REQ-033 EN=0, write 8 bytes 0x00..0x07 -> STATUS count=8, full=1; 9th write -> pslverr=1, count stays 8; set EN -> 8 starts in order 0x00..0x07.
REQ-034 Clear EN during 3rd of 5 bytes -> 3rd completes, no 4th tx_start, count=2.
REQ-035 IE=1, EN=1, push 2 bytes -> irq=0 while sending, irq=1 one cycle after return to IDLE with empty FIFO.
REQ-036 Read offset 0xC and write STATUS -> pslverr=1, prdata=0, no state change.
REQ-037 Assert rst_n=0 for one cycle while in WAIT_DONE with 3 bytes queued -> next cycle state IDLE, count=0, EN=0, tx_start=0.
